cpu_trace_checker: RTL
======================

// Module: cpu_trace_checker
// PURPOSE
//  Byte-serial checker for CPU write-back trace lines, one ASCII char per clk:
//  "^<time>@<pc>: $<reg> <= <data>#" (register) or "^<time>@<pc>: *<addr> <= <data>#" (memory).
//  Validates format and classifies semantic errors (time alignment, PC range, address range, register index).
//  Sits on the simulation/trace-replay path after the UART/char source; successor to the fixed-range checker.
//  Ranges, field lengths and counter width are parameters; a '^' restarts parsing from any state.
// PARAMETERS
//  TIME_MAXLEN  4          max decimal digits in time field (min 1)
//  REG_MAXLEN   4          max decimal digits in register index (min 1)
//  PC_LO        32'h3000   lowest legal PC (inclusive)
//  PC_HI        32'h4fff   highest legal PC (inclusive)
//  MEM_HI       32'h2fff   highest legal data address (inclusive, low bound 0)
//  GRF_NUM      32         number of GPRs; index >= GRF_NUM is an error
//  CNT_W        16         width of statistics counters
// PORTS
//  clk          in   1      clock, all state on rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  char         in   8      ASCII char, one consumed every clk
//  freq         in   16     time quantum; power of two, >= 2
//  format_type  out  2      0 none/invalid, 1 register line, 2 memory line
//  error_code   out  4      OR of: 1 time, 2 pc, 4 addr, 8 grf; 0 unless line done
//  line_done    out  1      1-cycle pulse: legal line just completed
//  line_cnt     out  CNT_W  legal lines seen (statistics, see CONFIGURATION)
//  err_cnt      out  CNT_W  legal lines with error_code != 0
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, format_type=0, error_code=0, line_done=0, counters=0. Reset dominates any char.
//  States: IDLE, TIME, PC, PRE_ADDR, REG, MEM, PRE_OP, OP1, PRE_DATA, DATA, DONE.
//  Any state: char=='^' -> TIME, clear num/len/err (mid-line restart; partial line discarded, no pulse).
//  IDLE: other chars ignored. DONE: non-'^' -> IDLE.
//  TIME: '0'-'9' accumulate (len>TIME_MAXLEN -> IDLE); '@' with len>=1 -> PC; err.time if time & ((freq>>1)-1) != 0.
//  PC: lowercase hex 'a'-'f'/digits, exactly 8 then ':'; err.pc if pc<PC_LO, pc>PC_HI or pc[1:0]!=0. -> PRE_ADDR.
//  PRE_ADDR: ' '* then '$'->REG or '*'->MEM.
//  REG: 1..REG_MAXLEN decimal digits; terminator ' '->PRE_OP or '<'->OP1; err.grf if idx>=GRF_NUM.
//  MEM: exactly 8 hex; terminator as REG; err.addr if addr>MEM_HI or addr[1:0]!=0.
//  PRE_OP: ' '* then '<' -> OP1. OP1: '=' -> PRE_DATA. PRE_DATA: ' '* then hex -> DATA (len=1).
//  DATA: exactly 8 hex then '#' -> DONE. Space inside data, 9th digit, uppercase, other char -> IDLE.
//  Any char not listed for the current state -> IDLE (format error, no outputs).
//  Outputs: format_type/error_code combinational from state, nonzero only in DONE, i.e. valid exactly
//  the cycle after '#' is sampled; back-to-back "#^" keeps them for one cycle only.
//  line_done registered high in DONE only (same cycle as format_type != 0).
//  Arithmetic: 32-bit accumulators, decimal = (n<<3)+(n<<1)+d; overflow beyond length limits impossible
//  because of length checks. Errors are accumulated and all applicable bits reported together.
// CONFIGURATION
//  CPU_TRACE_CHECKER_STATS_EN defined: line_cnt +1 on entry to DONE; err_cnt +1 on entry to DONE when err!=0;
//  both saturate at all-ones (no wrap); reset only by reset_n.
//  Not defined: line_cnt and err_cnt tied to 0, no counter flops; parser behaviour identical.
// TESTING
//  freq=2, "^1024@000030fc: $2 <= 89abcdef#" -> cycle after '#': format_type=1, error_code=0, line_done=1.
//  freq=8, "^13@00005000:*00003001<=00000000#" -> format_type=2, error_code=4'b0111 (time, pc, addr).
//  "^1@00003000: $32 <= 0000000g#" -> IDLE, format_type=0; then "$32" line legal -> error_code=8.
//  "^12345@..." (5 time digits) -> no line_done; "^12@0000300^1@00003000: $0<=00000000#" -> one legal line only.
//  STATS_EN, CNT_W=2: 5 legal lines (2 erroneous) -> line_cnt=3 (saturated), err_cnt=2.
//  reset_n low mid-DATA -> outputs 0 immediately (async); following full line parses normally.

Source files
------------

// File: rtl/cpu_trace_checker.sv
// Byte-serial parser/classifier for CPU write-back trace lines.
// Optional statistics counters: CPU_TRACE_CHECKER_STATS_EN.
module cpu_trace_checker #(
   parameter int unsigned TIME_MAXLEN = 4,
   parameter int unsigned REG_MAXLEN  = 4,
   parameter logic [31:0] PC_LO       = 32'h3000,
   parameter logic [31:0] PC_HI       = 32'h4fff,
   parameter logic [31:0] MEM_HI      = 32'h2fff,
   parameter int unsigned GRF_NUM     = 32,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [7:0]       char,
   input  logic [15:0]      freq,
   output logic [1:0]       format_type,
   output logic [3:0]       error_code,
   output logic             line_done,
   output logic [CNT_W-1:0] line_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic [3:0] {
      S_IDLE, S_TIME, S_PC, S_PRE_ADDR, S_REG, S_MEM,
      S_PRE_OP, S_OP1, S_PRE_DATA, S_DATA, S_DONE
   } state_e;

   localparam logic [7:0]  TMAX    = 8'(TIME_MAXLEN);
   localparam logic [7:0]  RMAX    = 8'(REG_MAXLEN);
   localparam logic [31:0] GRF_LIM = 32'(GRF_NUM);

   state_e      state_q, state_d;
   logic [31:0] num_q, num_d;
   logic [7:0]  len_q, len_d;
   logic [3:0]  err_q, err_d;
   logic        mem_q, mem_d;
   logic        line_done_q, line_done_d;

   logic        is_dig, is_hex, is_sp, is_term;
   logic [3:0]  nib;
   logic [15:0] fm1;
   logic [31:0] tmask, num_dec, num_hex;
   logic [7:0]  len_inc;

   always_comb begin
      is_dig  = (char >= "0") && (char <= "9");
      is_hex  = is_dig || ((char >= "a") && (char <= "f"));
      is_sp   = (char == " ");
      is_term = is_sp || (char == "<");
      nib     = is_dig ? char[3:0] : char[3:0] + 4'd9;
      fm1     = freq - 16'd1;
      tmask   = 32'(fm1 >> 1);
      num_dec = (num_q << 3) + (num_q << 1) + {28'h0, char[3:0]};
      num_hex = {num_q[27:0], nib};
      len_inc = len_q + 8'd1;
   end

   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      len_d   = len_q;
      err_d   = err_q;
      mem_d   = mem_q;
      if (char == "^") begin
         state_d = S_TIME;
         num_d   = '0;
         len_d   = '0;
         err_d   = '0;
         mem_d   = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_TIME: begin
               if (is_dig) begin
                  if (len_q >= TMAX) state_d = S_IDLE;
                  num_d = num_dec;
                  len_d = len_inc;
               end else if (char == "@" && len_q != 8'd0) begin
                  state_d  = S_PC;
                  err_d[0] = |(num_q & tmask);
                  num_d    = '0;
                  len_d    = '0;
               end else state_d = S_IDLE;
            end
            S_PC: begin
               if (is_hex) begin
                  if (len_q == 8'd8) state_d = S_IDLE;
                  num_d = num_hex;
                  len_d = len_inc;
               end else if (char == ":" && len_q == 8'd8) begin
                  state_d  = S_PRE_ADDR;
                  err_d[1] = (num_q < PC_LO) || (num_q > PC_HI)
                           || (num_q[1:0] != 2'b00);
               end else state_d = S_IDLE;
            end
            S_PRE_ADDR: begin
               num_d = '0;
               len_d = '0;
               if (char == "$") state_d = S_REG;
               else if (char == "*") begin
                  state_d = S_MEM;
                  mem_d   = 1'b1;
               end else if (!is_sp) state_d = S_IDLE;
            end
            S_REG: begin
               if (is_dig) begin
                  if (len_q >= RMAX) state_d = S_IDLE;
                  num_d = num_dec;
                  len_d = len_inc;
               end else if (is_term && len_q != 8'd0) begin
                  state_d  = is_sp ? S_PRE_OP : S_OP1;
                  err_d[3] = (num_q >= GRF_LIM);
               end else state_d = S_IDLE;
            end
            S_MEM: begin
               if (is_hex) begin
                  if (len_q == 8'd8) state_d = S_IDLE;
                  num_d = num_hex;
                  len_d = len_inc;
               end else if (is_term && len_q == 8'd8) begin
                  state_d  = is_sp ? S_PRE_OP : S_OP1;
                  err_d[2] = (num_q > MEM_HI) || (num_q[1:0] != 2'b00);
               end else state_d = S_IDLE;
            end
            S_PRE_OP: begin
               if (char == "<") state_d = S_OP1;
               else if (!is_sp) state_d = S_IDLE;
            end
            S_OP1: state_d = (char == "=") ? S_PRE_DATA : S_IDLE;
            S_PRE_DATA: begin
               if (is_hex) begin
                  state_d = S_DATA;
                  len_d   = 8'd1;
               end else if (!is_sp) state_d = S_IDLE;
            end
            S_DATA: begin
               if (is_hex) begin
                  if (len_q == 8'd8) state_d = S_IDLE;
                  len_d = len_inc;
               end else if (char == "#" && len_q == 8'd8) state_d = S_DONE;
               else state_d = S_IDLE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
      line_done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         num_q       <= '0;
         len_q       <= '0;
         err_q       <= '0;
         mem_q       <= 1'b0;
         line_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         num_q       <= num_d;
         len_q       <= len_d;
         err_q       <= err_d;
         mem_q       <= mem_d;
         line_done_q <= line_done_d;
      end
   end

   // Classification is only visible while the DONE state is held.
   assign format_type = (state_q == S_DONE) ? (mem_q ? 2'd2 : 2'd1) : 2'd0;
   assign error_code  = (state_q == S_DONE) ? err_q : 4'd0;
   assign line_done   = line_done_q;

`ifdef CPU_TRACE_CHECKER_STATS_EN
   logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      line_cnt_d = line_cnt_q;
      err_cnt_d  = err_cnt_q;
      if (state_d == S_DONE && state_q != S_DONE) begin
         if (!(&line_cnt_q)) line_cnt_d = line_cnt_q + CNT_W'(1);
         if (err_d != 4'd0 && !(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         line_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         line_cnt_q <= line_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign line_cnt = line_cnt_q;
   assign err_cnt  = err_cnt_q;
`else
   assign line_cnt = '0;
   assign err_cnt  = '0;
`endif

endmodule
